spi_mem_master: RTL and testbench

//  SPI initiator (mode 0, sck idles low) for the SPI memory core logic. Converts one

---
 rtl/spi_mem_master_pkg.sv | 23 ++
 rtl/spi_mem_master_if.sv | 30 +++
 rtl/spi_mem_master_clkgen.sv | 33 +++
 rtl/spi_mem_master.sv | 133 +++++++++++++
 tb/tb_spi_mem_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_master_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI memory initiator.
package spi_mem_master_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_BITS  = 8;   // address + rw byte

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    // Byte 0 = {addr, rw}; byte 1 = write data, forced to zero on reads so mosi idles low.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic              rw,
                                                          input logic [ADDR_W-1:0] addr,
                                                          input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] data;
        data = (rw == RW_WRITE) ? wdata : '0;
        return {addr, rw, data};
    endfunction

endpackage

// File: rtl/spi_mem_master_if.sv
// Host request/response handshake plus SPI pins for the SPI memory initiator.
interface spi_mem_master_if;
    import spi_mem_master_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              sck;
    logic              cs;
    logic              mosi;
    logic              miso;

    // Host and memory-pin side.
    modport master (
        output req_valid, req_rw, req_addr, req_wdata, miso,
        input  req_ready, rsp_valid, rsp_rdata, busy, sck, cs, mosi
    );

    // Initiator block side.
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, miso,
        output req_ready, rsp_valid, rsp_rdata, busy, sck, cs, mosi
    );

endinterface

// File: rtl/spi_mem_master_clkgen.sv
// Half-period divider: tick pulses every CLK_DIV clocks while enabled, counter held at 0 otherwise.
module spi_mem_master_clkgen #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned    CntW    = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    assign tick_o = en_i && (div_cnt_q == CntLast);

    always_comb begin
        div_cnt_d = div_cnt_q + CntW'(1);
        if (!en_i || tick_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator: one 16-bit {addr,rw,data} frame per accepted request, one in flight.
module spi_mem_master
    import spi_mem_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_mem_master_if.slave bus_io
);

    localparam logic [3:0] BitLast = 4'(FRAME_BITS - 1);
    localparam logic [3:0] BitData = 4'(ADDR_BITS);

    state_e                state_q;
    logic                  tick;
    logic                  accept;
    logic [FRAME_BITS-1:0] req_frame, tx_shift_q, tx_next;
    logic [DATA_W-1:0]     rx_shift_q, rsp_rdata_q;
    logic [3:0]            bit_cnt_q;
    logic                  rw_q, sck_q, cs_q, mosi_q;
    logic                  req_ready_q, rsp_valid_q, busy_q;
    logic                  miso_meta_q, miso_sync_q;

    spi_mem_master_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q != StIdle),
        .tick_o(tick)
    );

    assign accept    = bus_io.req_valid && req_ready_q && (state_q == StIdle);
    assign req_frame = build_frame(bus_io.req_rw, bus_io.req_addr, bus_io.req_wdata);
    assign tx_next   = tx_shift_q << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= bus_io.miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rsp_rdata_q <= '0;
            bit_cnt_q   <= '0;
            rw_q        <= RW_WRITE;
            sck_q       <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= StSetup;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b0;
                        tx_shift_q  <= req_frame;
                        mosi_q      <= req_frame[FRAME_BITS-1];
                        rw_q        <= bus_io.req_rw;
                        rx_shift_q  <= '0;
                        bit_cnt_q   <= '0;
                    end
                end
                StSetup: begin
                    if (tick) state_q <= StShift;
                end
                StShift: begin
                    if (tick && !sck_q) begin
                        sck_q <= 1'b1;
                    end else if (tick) begin
                        sck_q <= 1'b0;
                        // Last clk of the high phase: synchronised miso is settled here.
                        if (rw_q == RW_READ && bit_cnt_q >= BitData) begin
                            rx_shift_q <= {rx_shift_q[DATA_W-2:0], miso_sync_q};
                        end
                        if (bit_cnt_q == BitLast) begin
                            state_q <= StHold;
                            mosi_q  <= 1'b0;
                        end else begin
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            tx_shift_q <= tx_next;
                            mosi_q     <= tx_next[FRAME_BITS-1];
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        state_q     <= StGap;
                        cs_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (rw_q == RW_READ) ? rx_shift_q : '0;
                        bit_cnt_q   <= '0;
                    end
                end
                StGap: begin
                    // Two half-periods with cs high so the memory's FSM returns to idle.
                    if (tick && bit_cnt_q[0]) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end else if (tick) begin
                        bit_cnt_q <= 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.req_ready = req_ready_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.sck       = sck_q;
    assign bus_io.cs        = cs_q;
    assign bus_io.mosi      = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master against a behavioural mode-0 SPI memory model.
module tb_spi_mem_master;

    localparam int unsigned CLK_DIV = 8;
    localparam int          RSP_LAT = 34 * CLK_DIV + 1;
    localparam int          RDY_LAT = 36 * CLK_DIV + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    spi_mem_master_if bus ();

    spi_mem_master #(
        .CLK_DIV(CLK_DIV)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    // Memory model: shifts mosi on sck rise, drives miso on sck fall during a read data byte.
    logic [7:0]  mem [128] = '{default: 8'h00};
    logic [15:0] sl_shift  = 16'h0000;
    int          sl_rise   = 0;
    logic [6:0]  sl_addr   = 7'h00;
    logic        sl_rw     = 1'b0;
    int          sck_bad   = 0;
    logic [7:0]  rd_byte;

    always @(posedge bus.sck or negedge bus.cs) begin
        if (!bus.sck) begin
            sl_rise  = 0;
            sl_shift = 16'h0000;
        end else if (bus.cs) begin
            sck_bad++;
        end else begin
            sl_shift = {sl_shift[14:0], bus.mosi};
            sl_rise++;
            if (sl_rise == 8) begin
                sl_addr = sl_shift[7:1];
                sl_rw   = sl_shift[0];
            end
            if (sl_rise == 16 && !sl_rw) mem[sl_addr] = sl_shift[7:0];
        end
    end

    always @(negedge bus.sck) begin
        if (!bus.cs && sl_rw && sl_rise >= 8 && sl_rise < 16) begin
            rd_byte  = mem[sl_addr];
            bus.miso = rd_byte[3'(15 - sl_rise)];
        end
    end

    logic [7:0] rsp_log [$];
    int         gaps    [$];
    int         cs_hi_run = 0;

    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_log.push_back(bus.rsp_rdata);
    end

    always @(posedge clk) begin
        if (bus.cs) begin
            cs_hi_run++;
        end else if (cs_hi_run != 0) begin
            gaps.push_back(cs_hi_run);
            cs_hi_run = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
        end
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                           output int rsp_cyc, output int rdy_cyc, output logic [7:0] rdata);
        int n;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40 * CLK_DIV) begin
            @(posedge clk); #1;
            n++;
        end
        rsp_cyc = n + 1;
        rdata   = bus.rsp_rdata;
        total++;
        if (bus.rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", bus.rsp_valid, n);
        end
        while (!bus.req_ready && n < 40 * CLK_DIV) begin
            @(posedge clk); #1;
            n++;
        end
        rdy_cyc = n + 1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.cs, bus.sck, bus.mosi, bus.req_ready, bus.rsp_valid, bus.busy} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_pins: cs/sck/mosi/ready/rsp/busy=%b required 100000",
                     {bus.cs, bus.sck, bus.mosi, bus.req_ready, bus.rsp_valid, bus.busy});
        end
        total++;
        if (bus.rsp_rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_rdata: got %h required 00", bus.rsp_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus.req_ready, bus.busy, bus.cs} !== 3'b101) begin
            bad++;
            $display("FAIL reset_release: ready/busy/cs=%b required 101",
                     {bus.req_ready, bus.busy, bus.cs});
        end
    endtask

    task automatic test_write();
        int rc, yc, p0;
        logic [7:0] rd;
        p0 = rsp_log.size();
        run_txn(1'b0, 7'h12, 8'hA5, rc, yc, rd);
        total++;
        if (sl_shift !== 16'h24A5 || sl_rise != 16) begin
            bad++;
            $display("FAIL write_frame: got %h/%0d edges required 24a5/16", sl_shift, sl_rise);
        end
        total++;
        if (rd !== 8'h00) begin
            bad++;
            $display("FAIL write_rdata: got %h required 00", rd);
        end
        total++;
        if (rc != RSP_LAT) begin
            bad++;
            $display("FAIL write_rsp_latency: got %0d required %0d", rc, RSP_LAT);
        end
        total++;
        if (yc != RDY_LAT) begin
            bad++;
            $display("FAIL write_ready_latency: got %0d required %0d", yc, RDY_LAT);
        end
        total++;
        if (rsp_log.size() - p0 != 1) begin
            bad++;
            $display("FAIL write_rsp_pulses: got %0d required 1", rsp_log.size() - p0);
        end
        total++;
        if (mem[7'h12] !== 8'hA5) begin
            bad++;
            $display("FAIL write_mem: got %h required a5", mem[7'h12]);
        end
        total++;
        if (sck_bad != 0) begin
            bad++;
            $display("FAIL sck_while_cs_high: got %0d edges required 0", sck_bad);
        end
    endtask

    task automatic test_read();
        int rc, yc;
        logic [7:0] rd;
        run_txn(1'b1, 7'h12, 8'h5A, rc, yc, rd);
        total++;
        if (sl_shift !== 16'h2500) begin
            bad++;
            $display("FAIL read_frame: got %h required 2500", sl_shift);
        end
        total++;
        if (rd !== 8'hA5) begin
            bad++;
            $display("FAIL read_rdata: got %h required a5", rd);
        end
        total++;
        if (rc != RSP_LAT) begin
            bad++;
            $display("FAIL read_rsp_latency: got %0d required %0d", rc, RSP_LAT);
        end
    endtask

    task automatic test_boundary();
        int rc, yc;
        logic [7:0] rd;
        run_txn(1'b0, 7'h7F, 8'hFF, rc, yc, rd);
        total++;
        if (sl_shift !== 16'hFEFF) begin
            bad++;
            $display("FAIL bound_frame_7f: got %h required feff", sl_shift);
        end
        run_txn(1'b0, 7'h00, 8'h00, rc, yc, rd);
        run_txn(1'b1, 7'h7F, 8'h00, rc, yc, rd);
        total++;
        if (rd !== 8'hFF) begin
            bad++;
            $display("FAIL bound_read_7f: got %h required ff", rd);
        end
        run_txn(1'b1, 7'h00, 8'h00, rc, yc, rd);
        total++;
        if (rd !== 8'h00 || sl_shift !== 16'h0100) begin
            bad++;
            $display("FAIL bound_read_00: got data %h frame %h required 00 0100", rd, sl_shift);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] addrs [3] = '{7'h12, 7'h7F, 7'h00};
        logic [7:0] exp   [3] = '{8'hA5, 8'hFF, 8'h00};
        int p0, g0;
        p0 = rsp_log.size();
        g0 = gaps.size();
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_wdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = addrs[i];
            wait_ready();
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        wait_ready();
        total++;
        if (rsp_log.size() - p0 != 3) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d required 3", rsp_log.size() - p0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rsp_log[p0 + i] !== exp[i]) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: got %h required %h", i, rsp_log[p0 + i], exp[i]);
                end
            end
        end
        total++;
        if (gaps.size() - g0 != 3) begin
            bad++;
            $display("FAIL b2b_frames: got %0d required 3", gaps.size() - g0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (gaps[g0 + i] != 2 * CLK_DIV + 1) begin
                    bad++;
                    $display("FAIL b2b_cs_gap[%0d]: got %0d required %0d", i, gaps[g0 + i],
                             2 * CLK_DIV + 1);
                end
            end
        end
    endtask

    task automatic test_ignore_midframe();
        int p0, n;
        p0 = rsp_log.size();
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 7'h40;
        bus.req_wdata = 8'h3C;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (10 * CLK_DIV) @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'h41;
        bus.req_wdata = 8'hC3;
        @(posedge clk); #1;
        total++;
        if ({bus.busy, bus.req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL mid_busy_ready: got %b required 10", {bus.busy, bus.req_ready});
        end
        repeat (3 * CLK_DIV) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'h7E;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 40 * CLK_DIV) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sl_shift !== 16'h803C) begin
            bad++;
            $display("FAIL mid_frame: got %h required 803c", sl_shift);
        end
        total++;
        if ({mem[7'h40], mem[7'h41], mem[7'h7E]} !== 24'h3C0000) begin
            bad++;
            $display("FAIL mid_mem: got %h required 3c0000", {mem[7'h40], mem[7'h41], mem[7'h7E]});
        end
        total++;
        if (rsp_log.size() - p0 != 1) begin
            bad++;
            $display("FAIL mid_pulses: got %0d required 1", rsp_log.size() - p0);
        end
    endtask

    task automatic test_reset_midframe();
        int p0, n, rc, yc;
        logic [7:0] rd;
        p0 = rsp_log.size();
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 7'h54;
        bus.req_wdata = 8'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (sl_rise < 5 && n < 20 * CLK_DIV) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sl_rise != 5) begin
            bad++;
            $display("FAIL rst_reach_bit5: got %0d edges required 5", sl_rise);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.cs, bus.sck, bus.mosi, bus.busy, bus.req_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL rst_async_pins: cs/sck/mosi/busy/ready=%b required 10000",
                     {bus.cs, bus.sck, bus.mosi, bus.busy, bus.req_ready});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4 * CLK_DIV) @(posedge clk);
        #1;
        total++;
        if (rsp_log.size() != p0 || mem[7'h54] !== 8'h00) begin
            bad++;
            $display("FAIL rst_abort: got %0d pulses mem %h required 0 pulses mem 00",
                     rsp_log.size() - p0, mem[7'h54]);
        end
        run_txn(1'b1, 7'h12, 8'h00, rc, yc, rd);
        total++;
        if (rd !== 8'hA5 || rc != RSP_LAT || sl_shift !== 16'h2500) begin
            bad++;
            $display("FAIL rst_then_read: got %h lat %0d frame %h required a5 lat %0d frame 2500",
                     rd, rc, sl_shift, RSP_LAT);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 7'h00;
        bus.req_wdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_boundary();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
